maxpool_fifo: RTL
=================

# maxpool_fifo

Receiving end of the ReLU activation interface. Each `in_ready` beat delivers one 2x2 window of four signed activations. The block reduces the window to its signed maximum through a 2-stage pipeline and buffers results in a small first-word-fall-through FIFO. Downstream logic reads results with a valid/ready handshake. The ReLU side has no backpressure, so FIFO overrun drops the result and raises a sticky flag.

## Interface
- `DATA_SIZE`, 5, width of each signed activation lane and of the pooled result.
- `FIFO_DEPTH`, 4, number of buffered results; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_ready`  in  1  window beat strobe; lanes valid when high.
- `in0`, `in1`, `in2`, `in3`  in  DATA_SIZE each, signed  window lanes.
- `pool_valid`  out  1  FIFO non-empty; `pool_data` valid.
- `pool_data`  out  DATA_SIZE signed  FIFO head; 0 when empty.
- `pool_ready`  in  1  consumer accepts head this cycle.
- `overflow`  out  1  sticky; a result was dropped because the FIFO was full.
- `count`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- Stage 1 (registered, enabled by `in_ready`):
  - `m01 = max(in0,in1)`, `m23 = max(in2,in3)`.
  - Valid bit `v1 <= in_ready` every cycle.
  - Data registers hold their value when `in_ready` is low.
- Stage 2 (registered):
  - `m = max(m01,m23)`.
  - `v2 <= v1`.
- All comparisons are signed two's-complement, and results are DATA_SIZE wide with no rounding.
  - Negative inputs are legal and compared correctly.
  - On ties, either operand may be taken (values are equal).
- Push: when `v2` is high.
  - If `count < FIFO_DEPTH`, or a pop occurs in the same cycle, write `m` at the write pointer.
  - Otherwise drop `m` and set `overflow`.
- Pop: when `pool_valid && pool_ready`, advance the read pointer.
  - `pool_ready` while empty is ignored.
- Simultaneous push and pop:
  - `count` is unchanged; both pointers advance.
  - This is legal at full and must not set `overflow`.
  - At empty it is impossible (no pop when empty).
- Pointers wrap modulo FIFO_DEPTH.
- `overflow` clears only on `rst`.
- No bypass: a result pushed into an empty FIFO becomes visible the cycle after the write edge.

## Timing
- Reset: `v1`, `v2`, stage data, pointers, `count`, `overflow` all 0.
  - Hence `pool_valid = 0` and `pool_data = 0`.
- `rst` asserted mid-operation discards in-flight pipeline beats and buffered results the next edge.
  - `in_ready` in the reset cycle is ignored.
- Latency:
  - `in_ready` high at edge E → `v1` at E, `v2` at E+1, FIFO write at E+2.
  - `pool_valid` high and `pool_data` = result after E+2, i.e. 3 edges.
- Throughput: one window per cycle; back-to-back `in_ready` is fully supported.
- `pool_data` and `pool_valid` are combinational from FIFO state, with no dependence on `pool_ready`.
  - `pool_data` is stable while `pool_valid && !pool_ready`.
- `count` and `overflow` update on the same edge as the push or pop causing them.

## Structure
- Shared package `pool_pkg`:
  - `ACT_SIZE = 5`
  - `typedef logic signed [ACT_SIZE-1:0] act_t`
  - `POOL_FIFO_DEPTH = 4`
  - This package is shared with the ReLU and upstream stages.
- Sub-module `sync_fifo`, parameterised by width and depth. It provides:
  - registered memory with read/write pointers, occupancy count, full/empty;
  - same-cycle push/pop at full.
- `maxpool_fifo` holds the two compare stages, overflow logic, and the `sync_fifo` instance.

## Test plan
- Reset, then one beat `in0..3 = 3, 7, 1, 5` → `pool_valid` rises 3 edges later with `pool_data = 7`, `count = 1`; pop with `pool_ready` → `pool_valid = 0`, `count = 0`.
- Signed compare: beat `-4, -1, -16, -8` → `pool_data = -1`; beat `0, -3, 15, -16` → 15.
- Back-to-back 4 beats (maxima 2, 9, 4, 11), `pool_ready = 0` → `count = 4`, data order 2, 9, 4, 11 on popping; `overflow` stays 0.
- Full FIFO, `pool_ready = 0`, fifth beat (max 6) → dropped, `overflow = 1`, `count = 4`, head still 2. Then drain all four and reset → `overflow = 0`.
- Full FIFO with `pool_ready = 1` in the cycle the fifth result (max 6) is pushed → accepted, `overflow = 0`, `count = 4`, final drain order 9, 4, 11, 6.
- Reset mid-stream with two beats in pipeline and two results buffered → next cycle `pool_valid = 0`, `count = 0`, and no stale results appear afterwards.

Source files
------------

// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool_pkg
// Brief    : Activation sizing shared by the ReLU, upstream and pooling stages.
// Revision : 1.0
// ============================================================================
package pool_pkg;
  localparam int ACT_SIZE        = 5;
  typedef logic signed [ACT_SIZE-1:0] act_t;
  localparam int POOL_FIFO_DEPTH = 4;
endpackage
`default_nettype wire

// File: rtl/maxpool_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_fifo_if
// Brief    : Window input from the ReLU side plus the pooled-result read port.
// Revision : 1.0
// ============================================================================
interface maxpool_fifo_if
  import pool_pkg::*;
#(
  parameter int DATA_SIZE  = ACT_SIZE,
  parameter int FIFO_DEPTH = POOL_FIFO_DEPTH
) ();
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                        in_ready;
  logic signed [DATA_SIZE-1:0] in0;
  logic signed [DATA_SIZE-1:0] in1;
  logic signed [DATA_SIZE-1:0] in2;
  logic signed [DATA_SIZE-1:0] in3;
  logic                        pool_valid;
  logic signed [DATA_SIZE-1:0] pool_data;
  logic                        pool_ready;
  logic                        overflow;
  logic [CW-1:0]               count;

  modport slave (
    input  in_ready, in0, in1, in2, in3, pool_ready,
    output pool_valid, pool_data, overflow, count
  );

  modport master (
    output in_ready, in0, in1, in2, in3, pool_ready,
    input  pool_valid, pool_data, overflow, count
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word-fall-through FIFO; push is accepted at full when a pop
//            happens in the same cycle.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_push,
  input  wire logic [WIDTH-1:0]             i_wdata,
  input  wire logic                         i_pop,
  output logic      [WIDTH-1:0]             o_rdata,
  output logic                              o_full,
  output logic                              o_empty,
  output logic      [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/maxpool_fifo.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_fifo
// Brief    : 2x2 signed max-pool in two register stages feeding a result FIFO
//            with a sticky overrun flag.
// Revision : 1.0
// ============================================================================
module maxpool_fifo
  import pool_pkg::*;
#(
  parameter int DATA_SIZE  = ACT_SIZE,
  parameter int FIFO_DEPTH = POOL_FIFO_DEPTH
) (
  input  wire logic        clk,
  input  wire logic        rst,
  maxpool_fifo_if.slave    bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic signed [DATA_SIZE-1:0] w_m01;
  logic signed [DATA_SIZE-1:0] w_m23;
  logic signed [DATA_SIZE-1:0] w_m;
  logic signed [DATA_SIZE-1:0] r_m01;
  logic signed [DATA_SIZE-1:0] r_m23;
  logic signed [DATA_SIZE-1:0] r_m;
  logic                        r_v1;
  logic                        r_v2;
  logic                        r_overflow;
  logic [DATA_SIZE-1:0]        w_rdata;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_pop;
  logic [CW-1:0]               w_count;

  assign w_m01 = (bus.in0 > bus.in1) ? bus.in0 : bus.in1;
  assign w_m23 = (bus.in2 > bus.in3) ? bus.in2 : bus.in3;
  assign w_m   = (r_m01 > r_m23)     ? r_m01   : r_m23;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_m01 <= '0;
      r_m23 <= '0;
      r_v2  <= 1'b0;
      r_m   <= '0;
    end else begin
      r_v1 <= bus.in_ready;
      if (bus.in_ready) begin
        r_m01 <= w_m01;
        r_m23 <= w_m23;
      end
      r_v2 <= r_v1;
      r_m  <= w_m;
    end
  end

  assign w_pop = ~w_empty & bus.pool_ready;

  // A result at full survives only if the head leaves on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (r_v2 && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_v2),
    .i_wdata (r_m),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.pool_valid = ~w_empty;
  assign bus.pool_data  = w_rdata;
  assign bus.count      = w_count;
  assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire
